pwm_ramp_controller: RTL and testbench
======================================

// Module: pwm_ramp_controller
// PURPOSE
//  Soft-start/fade sequencer for a single PWM channel. Accepts a target duty
//  over a valid/ready handshake, then steps the live duty toward it by STEP
//  every DWELL PWM periods. Duty changes only at period boundaries, so no
//  runt or glitch pulses occur. Sits between the control/register logic and
//  the PWM pin, and owns the PWM timebase and compare.
// PARAMETERS
//  PERIOD  100  clocks per PWM period (>=2)
//  STEP    1    duty increment per ramp step, in counts (>=1)
//  DWELL   4    PWM periods per ramp step (>=1)
//  DW      $clog2(PERIOD+1) (derived localparam) duty width; duty==PERIOD is 100%
// PORTS
//  clk       in   1   clock; all logic is on the rising edge
//  reset     in   1   asynchronous, active-high reset
//  enable    in   1   1=run PWM; 0=output low, timebase held
//  tgt_duty  in   DW  requested duty; values >PERIOD saturate to PERIOD
//  tgt_valid in   1   target request
//  tgt_ready out  1   target accepted when tgt_valid&&tgt_ready at an edge
//  cur_duty  out  DW  current ramp value
//  busy      out  1   state!=IDLE
//  done      out  1   1-cycle pulse when the ramp completes
//  pwm_out   out  1   registered PWM output
// BEHAVIOUR
//  Reset: cnt=0, cur_duty=0, duty_active=0, pwm_out=0, state=IDLE,
//   tgt_ready=0, done=0, dwell_cnt=0. tgt_ready goes to 1 on the first edge
//   after reset is released. Reset asserted mid-ramp aborts immediately.
//  Timebase: cnt runs 0..PERIOD-1 and wraps. wrap = enable && cnt==PERIOD-1.
//   When enable=0, cnt is held at 0 and duty_active<=cur_duty every cycle.
//  Output: pwm_out <= enable && (cnt < duty_active). One clock of latency.
//   duty_active=0 gives constant low; duty_active=PERIOD gives constant high.
//  Shadow: duty_active loads cur_duty_next on each wrap edge, so a step
//   taken at a wrap applies to the very next period.
//  FSM (tgt_ready and done are registered; both are set on the edge that
//   enters IDLE):
//   IDLE: tgt_ready=1. On accept: tgt<=sat(tgt_duty), tgt_ready<=0, ->LOAD.
//   LOAD: if tgt==cur_duty -> IDLE (done=1). Otherwise dwell_cnt<=0, ->RAMP.
//   RAMP: on each wrap, dwell_cnt++. On a wrap with dwell_cnt==DWELL-1:
//    dwell_cnt<=0 and cur_duty steps toward tgt:
//    - up:   cur = (tgt-cur<=STEP) ? tgt : cur+STEP
//    - down: cur = (cur-tgt<=STEP) ? tgt : cur-STEP
//    Compute in DW+1 bits; never overshoot or underflow.
//    When cur_duty_next==tgt: -> IDLE (done=1) on that same edge.
//  No retarget mid-ramp: tgt_ready=0 outside IDLE.
//  enable=0 freezes the RAMP state; no wraps occur, so dwell and cur_duty
//   hold. The handshake still works in IDLE. When enable returns to 1, the
//   period restarts from cnt=0.
// STRUCTURE
//  pwm_pkg: state encoding localparams (IDLE/LOAD/RAMP) and the duty-width
//   function clog2(PERIOD+1), shared with other PWM blocks.
//  Sub-module pwm_timebase: counter (clk, reset, enable) -> cnt, wrap.
//  Top level holds the FSM, step arithmetic, shadow register and compare.
// TESTING (PERIOD=10, STEP=2, DWELL=2 unless stated)
//  1 Reset/release: pwm_out=0, cur_duty=0, tgt_ready=0 in reset; tgt_ready=1
//    one edge after release.
//  2 Ramp up with target 5: cur_duty=2 after wrap 2, 4 after wrap 4,
//    5 after wrap 6 (clamped); done pulse on wrap 6; busy drops the same
//    cycle; pwm high count per period matches duty_active.
//  3 Ramp down from 5 with target 0: cur_duty 3,1,0 on every 2nd wrap;
//    pwm_out constant low after the final step; done pulses once.
//  4 Target 15: saturates to 10; ramp ends at 10; pwm_out constant high
//    for full periods.
//  5 Target equal to cur_duty: done=1 and tgt_ready=1 two edges after
//    accept; pwm_out waveform unchanged; tgt_valid held high during
//    busy is not accepted.
//  6 enable=0 mid-ramp: pwm_out=0 next cycle and cur_duty frozen; on
//    re-enable the ramp resumes. Async reset mid-ramp: all outputs at
//    reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared definitions for the PWM blocks. Holds the ramp FSM
//                state encoding and the duty-width helper, which sizes a duty
//                value so that duty == PERIOD (100 %) is representable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    // Width of a duty value for a given period: 0..PERIOD inclusive.
    function automatic int duty_width(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
//  Module      : pwm_timebase
//  Description : Free-running PWM period counter, 0..PERIOD-1 with wrap.
//                Held at 0 while disabled so a re-enable starts a fresh
//                period.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                enable - 1 = count, 0 = hold counter at 0
//                cnt    - current position within the period
//                wrap   - high during the last clock of an enabled period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase #(
    parameter  int PERIOD = 100,
    localparam int CW     = $clog2(PERIOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_w;

    assign wrap_w = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (wrap_w) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_w;

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_controller.sv
// ============================================================================
//  Module      : pwm_ramp_controller
//  Description : Soft-start / fade sequencer for one PWM channel. Accepts a
//                target duty over valid/ready, then walks the live duty toward
//                it by STEP every DWELL PWM periods. The duty seen by the
//                comparator is a shadow copy that only updates at period
//                boundaries, so no runt pulses are produced.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-high reset
//                enable    - 1 = run PWM, 0 = output low, timebase held
//                tgt_duty  - requested duty, saturated to PERIOD
//                tgt_valid - target request
//                tgt_ready - target accepted on valid && ready
//                cur_duty  - current ramp value
//                busy      - ramp sequencer not idle
//                done      - one-cycle pulse when a ramp completes
//                pwm_out   - registered PWM output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter  int PERIOD = 100,
    parameter  int STEP   = 1,
    parameter  int DWELL  = 4,
    localparam int DW     = duty_width(PERIOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] tgt_duty,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    output logic [DW-1:0] cur_duty,
    output logic          busy,
    output logic          done,
    output logic          pwm_out
);

    localparam int CW  = $clog2(PERIOD);
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0]  DUTY_MAX   = DW'(PERIOD);
    // A step larger than the full range behaves exactly like a full-range
    // step, so clamping it keeps the arithmetic inside DW bits.
    localparam logic [DW-1:0]  STEP_C     = (STEP >= PERIOD) ? DW'(PERIOD) : DW'(STEP);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_w;
    logic          wrap_w;

    pwm_timebase #(
        .PERIOD (PERIOD)
    ) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .cnt    (cnt_w),
        .wrap   (wrap_w)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q,  state_d;
    logic [DW-1:0]  tgt_q,    tgt_d;
    logic [DW-1:0]  cur_q,    cur_d;
    logic [DWW-1:0] dwell_q,  dwell_d;
    logic           tgt_ready_q, tgt_ready_d;
    logic           done_q,   done_d;
    logic [DW-1:0]  duty_active_q;
    logic           pwm_q;

    logic           accept_w;
    logic [DW-1:0]  tgt_sat_w;

    assign accept_w  = tgt_valid && tgt_ready_q;
    assign tgt_sat_w = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;

    // ------------------------------------------------------------------
    // One ramp step toward the target. The distance is formed with a spare
    // bit; when the remaining distance fits in one step the target is
    // taken directly, which rules out overshoot and underflow.
    // ------------------------------------------------------------------
    logic          up_w;
    logic [DW:0]   diff_w;
    logic [DW-1:0] moved_w;
    logic [DW-1:0] step_w;

    always_comb begin
        up_w    = (tgt_q >= cur_q);
        diff_w  = up_w ? ({1'b0, tgt_q} - {1'b0, cur_q})
                       : ({1'b0, cur_q} - {1'b0, tgt_q});
        moved_w = up_w ? (cur_q + STEP_C) : (cur_q - STEP_C);
        step_w  = (diff_w <= {1'b0, STEP_C}) ? tgt_q : moved_w;
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    tgt_d   = tgt_sat_w;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tgt_q == cur_q) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = '0;
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // wrap never fires while disabled, so the ramp freezes.
                if (wrap_w) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        cur_d   = step_w;
                        if (step_w == tgt_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + DWW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Both flags are registered and take effect on the edge entering IDLE.
        tgt_ready_d = (state_d == ST_IDLE);
        done_d      = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            cur_q       <= '0;
            dwell_q     <= '0;
            tgt_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
            dwell_q     <= dwell_d;
            tgt_ready_q <= tgt_ready_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow duty and compare. Loading cur_d (not cur_q) on the wrap edge
    // lets a step taken at that wrap apply to the very next period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
        end else begin
            if (!enable) begin
                duty_active_q <= cur_q;
            end else if (wrap_w) begin
                duty_active_q <= cur_d;
            end
            pwm_q <= enable && (DW'(cnt_w) < duty_active_q);
        end
    end

    assign tgt_ready = tgt_ready_q;
    assign cur_duty  = cur_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign pwm_out   = pwm_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_controller.sv
// ============================================================================
//  Module      : tb_pwm_ramp_controller
//  Description : Directed self-checking bench for pwm_ramp_controller with
//                PERIOD=10, STEP=2, DWELL=2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_controller;

    localparam int PERIOD = 10;
    localparam int STEP   = 2;
    localparam int DWELL  = 2;
    localparam int DW     = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] tgt_duty;
    logic          tgt_valid;
    logic          tgt_ready;
    logic [DW-1:0] cur_duty;
    logic          busy;
    logic          done;
    logic          pwm_out;

    int total = 0;
    int bad   = 0;

    // ramp monitor results
    int seen[$];
    int gaps[$];
    int done_seen;
    int busy_at_done;
    int ready_while_busy;

    always #5 clk = ~clk;

    pwm_ramp_controller #(
        .PERIOD (PERIOD),
        .STEP   (STEP),
        .DWELL  (DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tgt_duty  (tgt_duty),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .cur_duty  (cur_duty),
        .busy      (busy),
        .done      (done),
        .pwm_out   (pwm_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until a done pulse (bounded), logging each new cur_duty value and
    // the cycle distance from the previous change.
    task automatic run_until_done(input int max_cycles);
        int prev;
        int last_change;
        int n;
        seen.delete();
        gaps.delete();
        done_seen        = 0;
        busy_at_done     = 1;
        ready_while_busy = 0;
        prev             = int'(cur_duty);
        last_change      = 0;
        n                = 0;
        while (done_seen == 0 && n < max_cycles) begin
            tick();
            n++;
            if (busy && tgt_ready) ready_while_busy++;
            if (int'(cur_duty) != prev) begin
                seen.push_back(int'(cur_duty));
                gaps.push_back(n - last_change);
                last_change = n;
                prev        = int'(cur_duty);
            end
            if (done) begin
                done_seen    = 1;
                busy_at_done = int'(busy);
            end
        end
    endtask

    task automatic count_cycles(input int n, output int highs, output int dones);
        highs = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out) highs++;
            if (done)    dones++;
        end
    endtask

    task automatic request(input logic [DW-1:0] d);
        tgt_duty  = d;
        tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
    endtask

    initial begin
        int highs;
        int dones;
        int n;
        int changes;
        int frozen;

        reset     = 1'b1;
        enable    = 1'b1;
        tgt_duty  = '0;
        tgt_valid = 1'b0;

        // ---------------- reset / release ----------------
        tick(); tick(); tick();
        check("rst_pwm",   32'(pwm_out),   0);
        check("rst_cur",   32'(cur_duty),  0);
        check("rst_ready", 32'(tgt_ready), 0);
        check("rst_busy",  32'(busy),      0);
        check("rst_done",  32'(done),      0);
        reset = 1'b0;
        #1;
        check("rel_ready_before_edge", 32'(tgt_ready), 0);
        tick();
        check("rel_ready", 32'(tgt_ready), 1);

        // ---------------- ramp up to 5 ----------------
        request(4'd5);
        check("up_accept_ready", 32'(tgt_ready), 0);
        check("up_accept_busy",  32'(busy),      1);
        run_until_done(300);
        check("up_done_seen", 32'(done_seen), 1);
        check("up_nsteps",    32'(seen.size()), 3);
        check("up_v0",        32'(seen[0]), 2);
        check("up_v1",        32'(seen[1]), 4);
        check("up_v2",        32'(seen[2]), 5);
        check("up_gap1",      32'(gaps[1]), 20);
        check("up_gap2",      32'(gaps[2]), 20);
        check("up_busy_at_done", 32'(busy_at_done), 0);
        check("up_ready_at_done", 32'(tgt_ready), 1);
        count_cycles(PERIOD, highs, dones);
        check("up_done_once", 32'(dones), 0);
        check("up_pwm_high",  32'(highs), 5);

        // ---------------- ramp down to 0 ----------------
        request(4'd0);
        run_until_done(300);
        check("dn_done_seen", 32'(done_seen), 1);
        check("dn_nsteps",    32'(seen.size()), 3);
        check("dn_v0",        32'(seen[0]), 3);
        check("dn_v1",        32'(seen[1]), 1);
        check("dn_v2",        32'(seen[2]), 0);
        check("dn_gap1",      32'(gaps[1]), 20);
        check("dn_gap2",      32'(gaps[2]), 20);
        count_cycles(3 * PERIOD, highs, dones);
        check("dn_pwm_high",  32'(highs), 0);
        check("dn_done_once", 32'(dones), 0);

        // ---------------- saturating target ----------------
        request(4'd15);
        run_until_done(600);
        check("sat_done_seen", 32'(done_seen), 1);
        check("sat_nsteps",    32'(seen.size()), 5);
        check("sat_final",     32'(cur_duty), 10);
        count_cycles(2 * PERIOD, highs, dones);
        check("sat_pwm_high",  32'(highs), 20);

        // ---------------- target equal to current ----------------
        tgt_duty  = 4'd10;
        tgt_valid = 1'b1;
        tick();
        check("eq_busy_load", 32'(busy), 1);
        check("eq_done_load", 32'(done), 0);
        check("eq_ready_load", 32'(tgt_ready), 0);
        tick();
        tgt_valid = 1'b0;
        check("eq_done",  32'(done),      1);
        check("eq_ready", 32'(tgt_ready), 1);
        check("eq_busy",  32'(busy),      0);
        count_cycles(PERIOD, highs, dones);
        check("eq_pwm_high", 32'(highs), 10);

        // ---------------- valid held high while busy ----------------
        tgt_duty  = 4'd4;
        tgt_valid = 1'b1;
        tick();
        tgt_duty  = 4'd0;
        run_until_done(400);
        tgt_valid = 1'b0;
        check("hv_done_seen",   32'(done_seen), 1);
        check("hv_nsteps",      32'(seen.size()), 3);
        check("hv_final",       32'(cur_duty), 4);
        check("hv_ready_busy",  32'(ready_while_busy), 0);
        tick();
        check("hv_no_reaccept", 32'(busy), 0);

        // ---------------- enable=0 mid-ramp ----------------
        request(4'd8);
        n = 0;
        while (cur_duty != 4'd6 && n < 200) begin
            tick();
            n++;
        end
        check("en_reach6", 32'(cur_duty), 6);
        enable = 1'b0;
        tick();
        check("en_pwm_low", 32'(pwm_out), 0);
        changes = 0;
        frozen  = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick();
            if (cur_duty != 4'd6) changes++;
            if (pwm_out)          frozen++;
        end
        check("en_cur_frozen", 32'(changes), 0);
        check("en_pwm_off",    32'(frozen),  0);
        check("en_busy_held",  32'(busy),    1);
        enable = 1'b1;
        run_until_done(300);
        check("en_resume_done", 32'(done_seen), 1);
        check("en_resume_steps", 32'(seen.size()), 1);
        check("en_resume_final", 32'(cur_duty), 8);

        // ---------------- async reset mid-ramp ----------------
        request(4'd0);
        for (int i = 0; i < 25; i++) tick();
        check("ar_pre_nonzero", 32'(cur_duty != 4'd0), 1);
        check("ar_pre_busy",    32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_cur",   32'(cur_duty),  0);
        check("ar_pwm",   32'(pwm_out),   0);
        check("ar_ready", 32'(tgt_ready), 0);
        check("ar_busy",  32'(busy),      0);
        check("ar_done",  32'(done),      0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
